// File: rtl/ysyx_mem_arbiter_if.sv
// Downstream AXI-lite-style memory bus driven by ysyx_mem_arbiter.
// The master modport is the arbiter side; the slave modport is the SoC crossbar side.
interface ysyx_mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic            m_arvalid;
  logic            m_arready;
  logic [XLEN-1:0] m_araddr;
  logic [7:0]      m_arstrb;
  logic            m_rvalid;
  logic            m_rready;
  logic [XLEN-1:0] m_rdata;
  logic            m_awvalid;
  logic            m_awready;
  logic [XLEN-1:0] m_awaddr;
  logic            m_wvalid;
  logic            m_wready;
  logic [XLEN-1:0] m_wdata;
  logic [7:0]      m_wstrb;
  logic            m_bvalid;
  logic            m_bready;

  modport master (
    output m_arvalid, m_araddr, m_arstrb, m_rready,
    output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    input  m_arready, m_rvalid, m_rdata, m_awready, m_wready, m_bvalid
  );

  modport slave (
    input  m_arvalid, m_araddr, m_arstrb, m_rready,
    input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    output m_arready, m_rvalid, m_rdata, m_awready, m_wready, m_bvalid
  );
endinterface

// File: rtl/ysyx_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory master among IFU read, LSU load and LSU store.
// Optional IFU anti-starvation guard: define YSYX_ARB_STARVE_GUARD_EN.
module ysyx_mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_pipeline,
  input  logic             ifu_arvalid,
  input  logic [XLEN-1:0]  ifu_araddr,
  output logic             ifu_rvalid,
  output logic [XLEN-1:0]  ifu_rdata,
  input  logic             lsu_arvalid,
  input  logic [XLEN-1:0]  lsu_araddr,
  input  logic [7:0]       lsu_rstrb,
  output logic             lsu_rvalid,
  output logic [XLEN-1:0]  lsu_rdata,
  input  logic             lsu_awvalid,
  input  logic [XLEN-1:0]  lsu_awaddr,
  input  logic [XLEN-1:0]  lsu_wdata,
  input  logic [7:0]       lsu_wstrb,
  output logic             lsu_wready,
  ysyx_mem_arbiter_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_B} state_e;
  typedef enum logic [1:0] {G_NONE, G_IFU, G_LD, G_ST} grant_e;

  state_e          state_q, state_d;
  grant_e          grant_q, grant_d;
  logic [XLEN-1:0] addr_q, sel_addr;
  logic [7:0]      strb_q, sel_strb;
  logic [XLEN-1:0] wdata_q;
  logic            aw_done_q, w_done_q, flushed_q;
  logic            ar_valid, aw_valid, w_valid, b_ready, r_fire, b_fire;
  logic            ifu_force;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d  = state_q;
    grant_d  = grant_q;
    sel_addr = '0;
    sel_strb = '0;
    ar_valid = 1'b0;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    b_ready  = 1'b0;
    r_fire   = 1'b0;
    b_fire   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        grant_d = G_NONE;
        // Fixed priority store > load > IFU, unless the starvation guard forces the IFU.
        if (ifu_force && ifu_arvalid) begin
          grant_d = G_IFU; state_d = S_AR; sel_addr = ifu_araddr; sel_strb = 8'hf;
        end else if (lsu_awvalid) begin
          grant_d = G_ST;  state_d = S_AW; sel_addr = lsu_awaddr; sel_strb = lsu_wstrb;
        end else if (lsu_arvalid && !flush_pipeline) begin
          grant_d = G_LD;  state_d = S_AR; sel_addr = lsu_araddr; sel_strb = lsu_rstrb;
        end else if (ifu_arvalid) begin
          grant_d = G_IFU; state_d = S_AR; sel_addr = ifu_araddr; sel_strb = 8'hf;
        end
      end
      S_AR: begin
        ar_valid = 1'b1;
        if (bus.m_arready) state_d = S_R;
      end
      S_R: begin
        if (bus.m_rvalid) begin
          r_fire  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_AW: begin
        aw_valid = !aw_done_q;
        w_valid  = !w_done_q;
        if ((aw_done_q || bus.m_awready) && (w_done_q || bus.m_wready)) state_d = S_B;
      end
      S_B: begin
        b_ready = 1'b1;
        if (bus.m_bvalid) begin
          b_fire  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= G_NONE;
      addr_q    <= '0;
      strb_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      grant_q <= grant_d;
      if (state_q == S_IDLE && state_d != S_IDLE) begin
        addr_q  <= sel_addr;
        strb_q  <= sel_strb;
        wdata_q <= lsu_wdata;
      end
      aw_done_q <= (state_q == S_AW) && (aw_done_q || bus.m_awready);
      w_done_q  <= (state_q == S_AW) && (w_done_q || bus.m_wready);
      flushed_q <= (state_d == S_AR || state_d == S_R) && (grant_q == G_LD)
                   && (flushed_q || flush_pipeline);
    end
  end

`ifdef YSYX_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_q;

  assign ifu_force = (starve_q == CNT_W'(STARVE_LIMIT));

  // Counts IDLE arbitrations the IFU requested but lost; saturates because a full count forces a win.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else if (state_q == S_IDLE && ifu_arvalid) begin
      if (grant_d == G_IFU)  starve_q <= '0;
      else if (!ifu_force)   starve_q <= starve_q + 1'b1;
    end
  end
`else
  logic unused_starve_limit;
  assign ifu_force           = 1'b0;
  assign unused_starve_limit = ^STARVE_LIMIT;
`endif

  assign bus.m_arvalid = ar_valid;
  assign bus.m_araddr  = ar_valid ? addr_q : '0;
  assign bus.m_arstrb  = ar_valid ? strb_q : '0;
  assign bus.m_rready  = 1'b1;
  assign bus.m_awvalid = aw_valid;
  assign bus.m_awaddr  = aw_valid ? addr_q : '0;
  assign bus.m_wvalid  = w_valid;
  assign bus.m_wdata   = w_valid ? wdata_q : '0;
  assign bus.m_wstrb   = w_valid ? strb_q : '0;
  assign bus.m_bready  = b_ready;

  // A flushed load still consumes its R beat, but the response is never reported.
  assign ifu_rvalid = r_fire && (grant_q == G_IFU);
  assign lsu_rvalid = r_fire && (grant_q == G_LD) && !flushed_q && !flush_pipeline;
  assign ifu_rdata  = ifu_rvalid ? bus.m_rdata : '0;
  assign lsu_rdata  = lsu_rvalid ? bus.m_rdata : '0;
  assign lsu_wready = b_fire;

  a_ifu_hold: assert property (@(posedge clock) disable iff (reset)
    ((state_q == S_AR || state_q == S_R) && grant_q == G_IFU) |-> ifu_arvalid);
  a_ld_hold: assert property (@(posedge clock) disable iff (reset)
    ((state_q == S_AR || state_q == S_R) && grant_q == G_LD)
      |-> (lsu_arvalid || flush_pipeline || flushed_q));
  a_st_hold: assert property (@(posedge clock) disable iff (reset)
    (state_q == S_AW || state_q == S_B) |-> lsu_awvalid);

endmodule
